// File: rtl/sobel_window_core.sv
// Sobel 3x3 window, gradient magnitude and edge output for column-beat pixel streams.
// Build option SOBEL_MAG_OUT_EN: emit the saturated magnitude instead of the thresholded edge bit.
module sobel_window_core #(
    parameter int IMG_WIDTH = 1920,
    parameter int DW        = 8,
    parameter int THRESH    = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] tap_top,
    input  logic [DW-1:0] tap_mid,
    input  logic [DW-1:0] tap_bot,
    input  logic          tap_valid,
    input  logic          tap_sol,
    input  logic          tap_eol,
    input  logic          tap_border,
    output logic          out_valid,
    output logic [DW-1:0] out_pix,
    output logic          out_sol,
    output logic          out_eol,
    output logic          err
);
    // Handshake: a column beat is taken on every cycle tap_valid is high (no ready,
    // no stall); out_valid is high for exactly one cycle per emitted pixel.

    localparam int CW = 11;
    localparam int SW = DW + 2;
    localparam int GW = DW + 3;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [GW-1:0] MAX_PIX  = GW'((1 << DW) - 1);
    localparam logic [31:0]   THRESH_W = THRESH;

    typedef enum logic [1:0] {IDLE, LINE, FLUSH} state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              col_q, col_d;
    logic                       border_q, border_d;
    logic                       err_q, err_d;
    // Row 0 = top, 2 = bottom; tap 0 = newest (right), 2 = oldest (left).
    logic [2:0][2:0][DW-1:0]    win_q, win_d;

    logic                       v0_q, v0_d, sol0_q, sol0_d, eol0_q, eol0_d, mask0_q, mask0_d;
    logic                       v1_q, v1_d, sol1_q, sol1_d, eol1_q, eol1_d, mask1_q, mask1_d;
    logic                       v2_q, v2_d, sol2_q, sol2_d, eol2_q, eol2_d, mask2_q, mask2_d;
    logic [GW-1:0]              gx_q, gx_d, gy_q, gy_d;
    logic [GW-1:0]              mag_q, mag_d;
    logic                       out_valid_q, out_valid_d, out_sol_q, out_sol_d, out_eol_q, out_eol_d;
    logic [DW-1:0]              out_pix_q, out_pix_d;

    logic                       accept;
    logic [CW-1:0]              beat_col;
    logic [SW-1:0]              gx_pos, gx_neg, gy_pos, gy_neg;
    logic [GW-1:0]              abs_x, abs_y;
    logic [DW-1:0]              pix;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        border_d = border_q;
        err_d    = err_q;
        win_d    = win_q;
        v0_d     = 1'b0;
        sol0_d   = 1'b0;
        eol0_d   = 1'b0;
        mask0_d  = 1'b0;
        accept   = 1'b0;
        beat_col = col_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (tap_valid) begin
                    if (tap_sol) begin
                        accept   = 1'b1;
                        beat_col = '0;
                        border_d = tap_border;
                        state_d  = tap_eol ? FLUSH : LINE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LINE: begin
                if (tap_valid) begin
                    accept = 1'b1;
                    if (tap_eol) state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = IDLE;
                if (tap_valid) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Accept of column c+1 completes the window centred on column c.
        if (accept) begin
            col_d    = beat_col;
            if (tap_eol && beat_col != LAST_COL) err_d = 1'b1;
            win_d[0] = {win_q[0][1:0], tap_top};
            win_d[1] = {win_q[1][1:0], tap_mid};
            win_d[2] = {win_q[2][1:0], tap_bot};
            if (beat_col != '0) begin
                v0_d    = 1'b1;
                sol0_d  = (beat_col == CW'(1));
                eol0_d  = ((beat_col - CW'(1)) == LAST_COL);
                mask0_d = border_q | sol0_d | eol0_d;
            end
        end else if (state_q == FLUSH) begin
            // Last column has no right neighbour: shift in zeros, result is masked.
            win_d[0] = {win_q[0][1:0], {DW{1'b0}}};
            win_d[1] = {win_q[1][1:0], {DW{1'b0}}};
            win_d[2] = {win_q[2][1:0], {DW{1'b0}}};
            v0_d     = 1'b1;
            sol0_d   = (col_q == '0);
            eol0_d   = 1'b1;
            mask0_d  = 1'b1;
        end

        gx_pos  = SW'(win_q[0][0]) + SW'({win_q[1][0], 1'b0}) + SW'(win_q[2][0]);
        gx_neg  = SW'(win_q[0][2]) + SW'({win_q[1][2], 1'b0}) + SW'(win_q[2][2]);
        gy_pos  = SW'(win_q[2][2]) + SW'({win_q[2][1], 1'b0}) + SW'(win_q[2][0]);
        gy_neg  = SW'(win_q[0][2]) + SW'({win_q[0][1], 1'b0}) + SW'(win_q[0][0]);
        gx_d    = GW'(gx_pos) - GW'(gx_neg);
        gy_d    = GW'(gy_pos) - GW'(gy_neg);
        v1_d    = v0_q;
        sol1_d  = sol0_q;
        eol1_d  = eol0_q;
        mask1_d = mask0_q;

        abs_x   = gx_q[GW-1] ? (~gx_q + GW'(1)) : gx_q;
        abs_y   = gy_q[GW-1] ? (~gy_q + GW'(1)) : gy_q;
        mag_d   = abs_x + abs_y;
        v2_d    = v1_q;
        sol2_d  = sol1_q;
        eol2_d  = eol1_q;
        mask2_d = mask1_q;

`ifdef SOBEL_MAG_OUT_EN
        pix = (mag_q > MAX_PIX) ? {DW{1'b1}} : mag_q[DW-1:0];
`else
        pix = ({{(32-GW){1'b0}}, mag_q} > THRESH_W) ? {DW{1'b1}} : {DW{1'b0}};
`endif
        out_valid_d = v2_q;
        out_sol_d   = v2_q & sol2_q;
        out_eol_d   = v2_q & eol2_q;
        out_pix_d   = (v2_q && !mask2_q) ? pix : {DW{1'b0}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            border_q    <= 1'b0;
            err_q       <= 1'b0;
            win_q       <= '0;
            v0_q        <= 1'b0;
            sol0_q      <= 1'b0;
            eol0_q      <= 1'b0;
            mask0_q     <= 1'b0;
            v1_q        <= 1'b0;
            sol1_q      <= 1'b0;
            eol1_q      <= 1'b0;
            mask1_q     <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            v2_q        <= 1'b0;
            sol2_q      <= 1'b0;
            eol2_q      <= 1'b0;
            mask2_q     <= 1'b0;
            mag_q       <= '0;
            out_valid_q <= 1'b0;
            out_sol_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_pix_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            border_q    <= border_d;
            err_q       <= err_d;
            win_q       <= win_d;
            v0_q        <= v0_d;
            sol0_q      <= sol0_d;
            eol0_q      <= eol0_d;
            mask0_q     <= mask0_d;
            v1_q        <= v1_d;
            sol1_q      <= sol1_d;
            eol1_q      <= eol1_d;
            mask1_q     <= mask1_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            v2_q        <= v2_d;
            sol2_q      <= sol2_d;
            eol2_q      <= eol2_d;
            mask2_q     <= mask2_d;
            mag_q       <= mag_d;
            out_valid_q <= out_valid_d;
            out_sol_q   <= out_sol_d;
            out_eol_q   <= out_eol_d;
            out_pix_q   <= out_pix_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_sol   = out_sol_q;
    assign out_eol   = out_eol_q;
    assign err       = err_q;

endmodule

// File: doc/sobel_window_core.md
Name: sobel_window_core

Overview:
- Downstream of the line-buffer FIFO pair (2048x24, afull at 1920) in the Sobel path.
- Consumes one column of three vertically aligned 8-bit pixels per beat (top = 2 lines ago, mid = 1 line ago, bot = current).
- Builds a 3x3 window and computes the Sobel gradient magnitude. Emits one thresholded edge pixel per input pixel, with line markers aligned to the output.

Parameters:
- IMG_WIDTH, 1920, active pixels per line; valid range 3..2048.
- DW, 8, pixel width of each tap.
- THRESH, 100, edge threshold; output is 0xFF when mag > THRESH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tap_top  in  DW  pixel from line y-2.
- tap_mid  in  DW  pixel from line y-1.
- tap_bot  in  DW  pixel from line y.
- tap_valid  in  1  column beat valid; no backpressure.
- tap_sol  in  1  first column of line; qualified by tap_valid.
- tap_eol  in  1  last column of line; qualified by tap_valid.
- tap_border  in  1  line is a top/bottom border row (whole output line forced 0); sampled with tap_sol.
- out_valid  out  1  output pixel valid.
- out_pix  out  DW  edge pixel.
- out_sol  out  1  first output pixel of line.
- out_eol  out  1  last output pixel of line.
- err  out  1  sticky protocol error.

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Reset: all outputs are 0, window registers are 0, col = 0, state IDLE, err = 0. Reset mid-line discards the window and pipeline contents; no partial-line output follows.
- FSM states and transitions:
  - IDLE -> LINE on tap_valid & tap_sol.
  - LINE -> FLUSH on tap_valid & tap_eol.
  - FLUSH -> IDLE after one cycle.
  - tap_valid & tap_sol in FLUSH is a protocol violation: err <= 1, beat dropped, FSM still goes to IDLE.
  - Minimum horizontal blank is therefore 1 cycle.
  - tap_valid without tap_sol in IDLE: beat dropped, err <= 1.
- Column counter col (11 bits):
  - Set to 0 on sol; increments on each accepted beat.
  - tap_eol with col != IMG_WIDTH-1: err <= 1, flush proceeds normally.
- Window:
  - Three 3-deep shift registers (one per row), shifted on each accepted beat.
  - Output for column c is triggered by the accept of column c+1.
  - Output for column IMG_WIDTH-1 is triggered by the FLUSH cycle.
  - Column 0 accept triggers nothing.
- Pipeline, relative to the trigger edge n:
  - n+1: Gx, Gy registered, 11-bit signed.
    - Gx = (TR + 2MR + BR) - (TL + 2ML + BL)
    - Gy = (BL + 2BM + BR) - (TL + 2TM + TR)
    - Range ±1020.
  - n+2: mag = |Gx| + |Gy| registered, 11-bit unsigned, max 2040, no overflow.
  - n+3: out_valid = 1; out_pix = (mag > THRESH) ? all-ones : 0.
- Borders: output is forced to 0 for column 0, column IMG_WIDTH-1, and every column of a line flagged tap_border. Arithmetic still runs; only the result is masked.
- Markers: out_sol accompanies output column 0 and out_eol accompanies output column IMG_WIDTH-1, delayed through the same pipeline.
- Output count: exactly one output per accepted input pixel of a well-formed line.
- err: set as above, cleared only by rst.

Optional Feature:
- Macro: SOBEL_MAG_OUT_EN.
- Defined: out_pix = min(mag, 2^DW - 1), saturated magnitude. THRESH is unused. Border forcing to 0 still applies.
- Undefined: binary thresholded output as specified above.

Test Plan:
- Flat field: IMG_WIDTH=8, all taps = 50, tap_border=0 -> 8 outputs, all 0x00; out_sol on first output, out_eol on eighth; first out_valid 3 cycles after the column-1 accept edge.
- Vertical step: top/mid/bot = 0 for cols 0-3 and 200 for cols 4-7 (IMG_WIDTH=8) -> Gx=800 at cols 3 and 4, so out_pix = 0xFF at cols 3 and 4, 0 elsewhere. With SOBEL_MAG_OUT_EN: 0xFF (saturated from 800).
- Horizontal step: top=0, mid=0, bot=255 -> Gy=1020, interior cols = 0xFF. Same line with tap_border=1 -> all 0.
- Threshold edge, THRESH=100: window giving mag=100 -> 0x00; window giving mag=101 -> 0xFF.
- Protocol errors:
  - tap_eol at col 5 with IMG_WIDTH=8 -> err=1, flush output still produced.
  - tap_sol in the FLUSH cycle -> err=1, beat dropped.
  - err stays 1 until rst.
- Reset mid-line: rst at col 4 -> next cycle all outputs 0; no out_valid until the next complete sol line produces output.
